wbgpiox: RTL and testbench

Next-generation Wishbone GPIO controller.
- Up to 32 pins, each with a per-pin output-enable (direction) bit.
- Atomic set/clear output registers, so an interrupt context can change pins without read-modify-write.
- Per-pin rising/falling edge interrupt enables, with a sticky write-1-to-clear pending register.
- Sits on the 32-bit pipelined Wishbone peripheral bus. Drives pad tri-state logic in the board top level. o_int feeds the interrupt controller.

---
 rtl/wbgpiox.sv | 102 ++++++++++
 tb/tb_wbgpiox.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wbgpiox.sv
// rtl/wbgpiox.sv - Wishbone GPIO controller with set/clear outputs and edge interrupts
module wbgpiox #(
    parameter int               NPINS       = 32,
    parameter logic [NPINS-1:0] DEFAULT_OUT = {NPINS{1'b0}},
    parameter logic [NPINS-1:0] DEFAULT_DIR = {NPINS{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [2:0]       i_wb_addr,
    input  logic [31:0]      i_wb_data,
    input  logic [3:0]       i_wb_sel,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_data,
    input  logic [NPINS-1:0] i_gpio,
    output logic [NPINS-1:0] o_gpio,
    output logic [NPINS-1:0] o_gpio_oe,
    output logic             o_int
);

    localparam logic [2:0] A_IN = 3'd0, A_OUT = 3'd1, A_SET = 3'd2, A_CLR = 3'd3;
    localparam logic [2:0] A_DIR = 3'd4, A_RISE = 3'd5, A_FALL = 3'd6, A_PEND = 3'd7;

    logic [NPINS-1:0] out_reg, dir_reg, rise_en, fall_en, pend;
    logic [NPINS-1:0] sync_x, sync_q, sync_r;
    logic [NPINS-1:0] wmask, wbits, pend_clr, rise, fall, rd_pins;
    logic [31:0]      lane_mask, rd_word;
    logic             wr;

    // Upper data bits are dropped when NPINS < 32.
    logic unused;
    assign unused = &{1'b0, i_wb_data};

    assign lane_mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    assign wmask     = lane_mask[NPINS-1:0];
    assign wbits     = i_wb_data[NPINS-1:0] & wmask;
    assign wr        = i_wb_stb && i_wb_we;
    assign pend_clr  = (wr && i_wb_addr == A_PEND) ? wbits : '0;

    assign rise = sync_q & ~sync_r;
    assign fall = ~sync_q & sync_r;

    assign o_wb_stall = 1'b0;
    assign o_gpio     = out_reg;
    assign o_gpio_oe  = dir_reg;

    always_comb begin
        rd_pins = '0;
        case (i_wb_addr)
            A_IN:                rd_pins = sync_q;
            A_OUT, A_SET, A_CLR: rd_pins = out_reg;
            A_DIR:               rd_pins = dir_reg;
            A_RISE:              rd_pins = rise_en;
            A_FALL:              rd_pins = fall_en;
            A_PEND:              rd_pins = pend;
            default:             rd_pins = '0;
        endcase
        rd_word = '0;
        rd_word[NPINS-1:0] = rd_pins;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            out_reg   <= DEFAULT_OUT;
            dir_reg   <= DEFAULT_DIR;
            rise_en   <= '0;
            fall_en   <= '0;
            pend      <= '0;
            sync_x    <= '0;
            sync_q    <= '0;
            sync_r    <= '0;
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
            o_int     <= 1'b0;
        end else begin
            if (wr) begin
                case (i_wb_addr)
                    A_OUT:   out_reg <= (out_reg & ~wmask) | wbits;
                    A_SET:   out_reg <= out_reg | wbits;
                    A_CLR:   out_reg <= out_reg & ~wbits;
                    A_DIR:   dir_reg <= (dir_reg & ~wmask) | wbits;
                    A_RISE:  rise_en <= (rise_en & ~wmask) | wbits;
                    A_FALL:  fall_en <= (fall_en & ~wmask) | wbits;
                    default: ;
                endcase
            end
            // A fresh edge outranks a same-cycle write-1-to-clear.
            pend      <= (pend & ~pend_clr) | (rise & rise_en) | (fall & fall_en);
            sync_x    <= i_gpio;
            sync_q    <= sync_x;
            sync_r    <= sync_q;
            o_wb_ack  <= i_wb_stb && i_wb_cyc;
            if (i_wb_stb)
                o_wb_data <= rd_word;
            o_int     <= |pend;
        end
    end

endmodule

// File: tb/tb_wbgpiox.sv
// tb/tb_wbgpiox.sv - self-checking bench for wbgpiox
module tb_wbgpiox;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] gpio;

    logic        stall1, ack1, int1;
    logic [31:0] rdata1, gpo1, oe1;
    logic        stall2, ack2, int2;
    logic [31:0] rdata2;
    logic [7:0]  gpo2, oe2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wbgpiox #(.NPINS(32), .DEFAULT_OUT(32'h0000_00A5), .DEFAULT_DIR(32'h0)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall1), .o_wb_ack(ack1), .o_wb_data(rdata1),
        .i_gpio(gpio), .o_gpio(gpo1), .o_gpio_oe(oe1), .o_int(int1)
    );

    wbgpiox #(.NPINS(8), .DEFAULT_OUT(8'h00), .DEFAULT_DIR(8'h00)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall2), .o_wb_ack(ack2), .o_wb_data(rdata2),
        .i_gpio(gpio[7:0]), .o_gpio(gpo2), .o_gpio_oe(oe2), .o_int(int2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r1, output logic [31:0] r2);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("ack", 32'(ack1), 32'h1);
        r1 = rdata1;
        r2 = rdata2;
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    typedef struct {
        logic        w;
        logic [2:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t tab[21];
    logic [31:0] r1, r2, m[8], mk, ex, newp;
    int k;

    initial begin
        tab[0]  = '{1'b0, 3'd0, 32'h0,        4'hF, 32'h1234_5678};
        tab[1]  = '{1'b0, 3'd1, 32'h0,        4'hF, 32'h0000_00A5};
        tab[2]  = '{1'b0, 3'd2, 32'h0,        4'hF, 32'h0000_00A5};
        tab[3]  = '{1'b0, 3'd3, 32'h0,        4'hF, 32'h0000_00A5};
        tab[4]  = '{1'b0, 3'd4, 32'h0,        4'hF, 32'h0};
        tab[5]  = '{1'b0, 3'd5, 32'h0,        4'hF, 32'h0};
        tab[6]  = '{1'b0, 3'd6, 32'h0,        4'hF, 32'h0};
        tab[7]  = '{1'b0, 3'd7, 32'h0,        4'hF, 32'h0};
        tab[8]  = '{1'b1, 3'd1, 32'hF0,       4'hF, 32'h0000_00A5};
        tab[9]  = '{1'b1, 3'd2, 32'h0F,       4'h1, 32'h0000_00F0};
        tab[10] = '{1'b1, 3'd3, 32'h81,       4'hF, 32'h0000_00FF};
        tab[11] = '{1'b0, 3'd1, 32'h0,        4'hF, 32'h0000_007E};
        tab[12] = '{1'b1, 3'd2, 32'hFF,       4'h0, 32'h0000_007E};
        tab[13] = '{1'b0, 3'd1, 32'h0,        4'hF, 32'h0000_007E};
        tab[14] = '{1'b1, 3'd0, 32'h0,        4'hF, 32'h1234_5678};
        tab[15] = '{1'b1, 3'd4, 32'hFFFF_0000, 4'hC, 32'h0};
        tab[16] = '{1'b0, 3'd4, 32'h0,        4'hF, 32'hFFFF_0000};
        tab[17] = '{1'b1, 3'd4, 32'hFFFF_FFFF, 4'h3, 32'hFFFF_0000};
        tab[18] = '{1'b0, 3'd4, 32'h0,        4'hF, 32'hFFFF_FFFF};
        tab[19] = '{1'b1, 3'd4, 32'h0,        4'hF, 32'hFFFF_FFFF};
        tab[20] = '{1'b0, 3'd4, 32'h0,        4'hF, 32'h0};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
        gpio = 32'h1234_5678;
        #3;
        chk("rst_gpio", gpo1, 32'h0000_00A5);
        chk("rst_oe", oe1, 32'h0);
        chk("rst_int", 32'(int1), 32'h0);
        chk("rst_ack", 32'(ack1), 32'h0);
        chk("rst_rdata", rdata1, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Register map, byte lanes and set/clear through the vector table
        for (int i = 0; i < 21; i++) begin
            wb(tab[i].w, tab[i].a, tab[i].d, tab[i].s, r1, r2);
            chk($sformatf("tab%0d", i), r1, tab[i].exp);
        end
        chk("gpio_out", gpo1, 32'h0000_007E);
        chk("gpio_oe", oe1, 32'h0);

        // Rising edge on pin 0: PEND at N+2, o_int at N+3
        wb(1'b1, 3'd5, 32'h1, 4'hF, r1, r2);
        wb(1'b1, 3'd6, 32'h0, 4'hF, r1, r2);
        @(negedge clk); gpio[0] = 1'b1;
        @(posedge clk); #1;
        chk("ack_drop", 32'(ack1), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("int_n2", 32'(int1), 32'h0);
        @(posedge clk); #1;
        chk("int_n3", 32'(int1), 32'h1);
        wb(1'b0, 3'd7, 32'h0, 4'hF, r1, r2);
        chk("pend_rise", r1, 32'h1);
        wb(1'b1, 3'd7, 32'h1, 4'hF, r1, r2);
        @(posedge clk); #1;
        chk("int_clr", 32'(int1), 32'h0);
        @(negedge clk); gpio[0] = 1'b0;
        repeat (5) @(posedge clk);
        wb(1'b0, 3'd7, 32'h0, 4'hF, r1, r2);
        chk("pend_nofall", r1, 32'h0);
        chk("int_nofall", 32'(int1), 32'h0);

        // W1C landing on the same edge as a new rising edge
        @(negedge clk); gpio[0] = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("int_pre", 32'(int1), 32'h1);
        @(negedge clk); gpio[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); gpio[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wb(1'b1, 3'd7, 32'h1, 4'hF, r1, r2);
        chk("int_race0", 32'(int1), 32'h1);
        @(posedge clk); #1;
        chk("int_race1", 32'(int1), 32'h1);
        wb(1'b0, 3'd7, 32'h0, 4'hF, r1, r2);
        chk("pend_race", r1, 32'h1);
        wb(1'b1, 3'd7, 32'h1, 4'hF, r1, r2);
        chk("int_late_hold", 32'(int1), 32'h1);
        @(posedge clk); #1;
        chk("int_late_clr", 32'(int1), 32'h0);

        // Narrow instance: unimplemented bits and sub-cycle pulses
        wb(1'b1, 3'd4, 32'hFFFF_FFFF, 4'hF, r1, r2);
        wb(1'b0, 3'd4, 32'h0, 4'hF, r1, r2);
        chk("dir8", r2, 32'h0000_00FF);
        chk("dir32", r1, 32'hFFFF_FFFF);
        chk("oe8", 32'(oe2), 32'h0000_00FF);
        wb(1'b1, 3'd5, 32'hFF, 4'hF, r1, r2);
        wb(1'b1, 3'd6, 32'hFF, 4'hF, r1, r2);
        wb(1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, r1, r2);
        @(posedge clk); #2; gpio[7] = 1'b1; #3; gpio[7] = 1'b0;
        repeat (5) @(posedge clk);
        wb(1'b0, 3'd7, 32'h0, 4'hF, r1, r2);
        chk("glitch_miss", r2, 32'h0);
        @(negedge clk); gpio[7] = 1'b1;
        @(posedge clk); #2; gpio[7] = 1'b0;
        repeat (5) @(posedge clk);
        wb(1'b0, 3'd7, 32'h0, 4'hF, r1, r2);
        chk("glitch_catch", r2, 32'h0000_0080);

        // Asynchronous reset with an outstanding strobe and PEND=0xFF
        wb(1'b1, 3'd6, 32'h0, 4'hF, r1, r2);
        @(negedge clk); gpio[7:0] = 8'h00;
        repeat (5) @(posedge clk);
        wb(1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, r1, r2);
        @(negedge clk); gpio[7:0] = 8'hFF;
        repeat (5) @(posedge clk);
        wb(1'b0, 3'd7, 32'h0, 4'hF, r1, r2);
        chk("pend_ff", r1, 32'h0000_00FF);
        chk("int_ff", 32'(int1), 32'h1);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 3'd7;
        @(posedge clk); #1;
        chk("ack_pre_rst", 32'(ack1), 32'h1);
        #2; rst = 1'b1; #1;
        chk("ack_rst", 32'(ack1), 32'h0);
        chk("int_rst", 32'(int1), 32'h0);
        chk("gpio_rst", gpo1, 32'h0000_00A5);
        @(posedge clk); #1;
        chk("ack_rst_hold", 32'(ack1), 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        wb(1'b0, 3'd7, 32'h0, 4'hF, r1, r2);
        chk("pend_after_rst", r1, 32'h0);

        // Randomised traffic against a register-level model
        m[0] = 32'h0; m[1] = 32'h0000_00A5; m[2] = 32'h0; m[3] = 32'h0;
        m[4] = 32'h0; m[5] = 32'h0; m[6] = 32'h0; m[7] = 32'h0;
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 8);
            if (k == 8) begin
                newp = $urandom;
                m[7] = m[7] | ((newp & ~gpio) & m[5]) | ((~newp & gpio) & m[6]);
                @(negedge clk); gpio = newp;
                repeat (5) @(posedge clk); #1;
                chk("rnd_int", 32'(int1), 32'(m[7] != 32'h0));
            end else begin
                logic        w;
                logic [31:0] d;
                logic [3:0]  s;
                w = 1'($urandom_range(0, 1));
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                ex = (k == 0) ? gpio : (k == 2 || k == 3) ? m[1] : m[k];
                wb(w, 3'(k), d, s, r1, r2);
                chk($sformatf("rnd_rd%0d", k), r1, ex);
                if (w) begin
                    mk = lanes(s);
                    case (k)
                        1, 4, 5, 6: m[k] = (m[k] & ~mk) | (d & mk);
                        2: m[1] = m[1] | (d & mk);
                        3: m[1] = m[1] & ~(d & mk);
                        7: m[7] = m[7] & ~(d & mk);
                        default: ;
                    endcase
                end
                chk("rnd_gpio", gpo1, m[1]);
                chk("rnd_oe", oe1, m[4]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
